// File: rtl/vga_timing_ctrl_pkg.sv
// Shared definitions for the VGA timing path: FSM encoding, configuration
// field widths and the shadowed timing configuration record.
package vga_timing_ctrl_pkg;

  localparam int HCNT_W        = 11;
  localparam int HPULSE_W      = 8;
  localparam int HDATA_BEGIN_W = 8;
  localparam int HDATA_END_W   = 10;
  localparam int VCNT_W        = 9;
  localparam int VPULSE_W      = 3;
  localparam int VDATA_BEGIN_W = 5;
  localparam int VDATA_END_W   = 9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [HCNT_W-1:0]        hsync_end;
    logic [HPULSE_W-1:0]      hpulse_end;
    logic [HDATA_BEGIN_W-1:0] hdata_begin;
    logic [HDATA_END_W-1:0]   hdata_end;
    logic [VCNT_W-1:0]        vsync_end;
    logic [VPULSE_W-1:0]      vpulse_end;
    logic [VDATA_BEGIN_W-1:0] vdata_begin;
    logic [VDATA_END_W-1:0]   vdata_end;
  } timing_cfg_t;

  // Half-open window test [lo, hi); an empty or inverted window never matches.
  function automatic logic in_window(input logic [HCNT_W-1:0] cnt,
                                     input logic [HCNT_W-1:0] lo,
                                     input logic [HCNT_W-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Configuration and video-timing bundle between the configuration unit,
// the timing controller and the pixel read path.
interface vga_timing_ctrl_if
  import vga_timing_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
);

  logic                      enable_i;
  logic [HCNT_W-1:0]         hsync_end_i;
  logic [HPULSE_W-1:0]       hpulse_end_i;
  logic [HDATA_BEGIN_W-1:0]  hdata_begin_i;
  logic [HDATA_END_W-1:0]    hdata_end_i;
  logic [VCNT_W-1:0]         vsync_end_i;
  logic [VPULSE_W-1:0]       vpulse_end_i;
  logic [VDATA_BEGIN_W-1:0]  vdata_begin_i;
  logic [VDATA_END_W-1:0]    vdata_end_i;
  logic [ADDR_WIDTH-1:0]     base_addr_i;
  logic [ADDR_WIDTH-1:0]     top_addr_i;

  logic                      hsync_o;
  logic                      vsync_o;
  logic                      de_o;
  logic [ADDR_WIDTH-1:0]     pix_addr_o;
  logic                      line_start_o;
  logic                      frame_start_o;
  logic                      busy_o;

  // Timing controller side.
  modport master (
    input  enable_i, hsync_end_i, hpulse_end_i, hdata_begin_i, hdata_end_i,
           vsync_end_i, vpulse_end_i, vdata_begin_i, vdata_end_i,
           base_addr_i, top_addr_i,
    output hsync_o, vsync_o, de_o, pix_addr_o, line_start_o, frame_start_o,
           busy_o
  );

  // Configuration source / pixel path side.
  modport slave (
    output enable_i, hsync_end_i, hpulse_end_i, hdata_begin_i, hdata_end_i,
           vsync_end_i, vpulse_end_i, vdata_begin_i, vdata_end_i,
           base_addr_i, top_addr_i,
    input  hsync_o, vsync_o, de_o, pix_addr_o, line_start_o, frame_start_o,
           busy_o
  );

endinterface

// File: rtl/vga_scan_counter.sv
// Wrapping scan counter: counts 0..wrap_val while enabled; carry flags the
// wrap cycle so a slower counter can be chained on it.
module vga_scan_counter #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] wrap_val,
  output logic [WIDTH-1:0] cnt,
  output logic             carry
);

  assign carry = en && (cnt == wrap_val);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= carry ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: shadowed scan timing, sync/DE/marker generation and
// frame-buffer fetch address sequencing, all outputs registered.
module vga_timing_ctrl
  import vga_timing_ctrl_pkg::*;
#(
  parameter int   ADDR_WIDTH = 32,
  parameter logic SYNC_POL   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_ctrl_if.master bus
);

  state_t                state, state_nxt;
  timing_cfg_t           cfg_in, sh_cfg;
  logic [ADDR_WIDTH-1:0] sh_base, sh_top, addr;

  logic [HCNT_W-1:0]     hcnt;
  logic [VCNT_W-1:0]     vcnt;
  logic                  h_carry, v_carry;

  logic                  run, load_cfg, eof;
  logic                  hact, vact, de, hs_act, vs_act;

  assign cfg_in = '{
    hsync_end:   bus.hsync_end_i,
    hpulse_end:  bus.hpulse_end_i,
    hdata_begin: bus.hdata_begin_i,
    hdata_end:   bus.hdata_end_i,
    vsync_end:   bus.vsync_end_i,
    vpulse_end:  bus.vpulse_end_i,
    vdata_begin: bus.vdata_begin_i,
    vdata_end:   bus.vdata_end_i
  };

  // Counters are held at zero while idle, so entering RUN starts at hcnt=vcnt=0.
  vga_scan_counter #(.WIDTH(HCNT_W)) u_hcnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (!run),
    .en       (run),
    .wrap_val (sh_cfg.hsync_end),
    .cnt      (hcnt),
    .carry    (h_carry)
  );

  vga_scan_counter #(.WIDTH(VCNT_W)) u_vcnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (!run),
    .en       (h_carry),
    .wrap_val (sh_cfg.vsync_end),
    .cnt      (vcnt),
    .carry    (v_carry)
  );

  assign eof = v_carry;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.enable_i)        state_nxt = ST_RUN;
      ST_RUN:  if (eof && !bus.enable_i) state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    run      = 1'b0;
    load_cfg = 1'b0;
    case (state)
      ST_IDLE: load_cfg = bus.enable_i;
      ST_RUN: begin
        run      = 1'b1;
        load_cfg = eof && bus.enable_i;
      end
      default: ;
    endcase
  end

  assign hact   = in_window(hcnt, HCNT_W'(sh_cfg.hdata_begin), HCNT_W'(sh_cfg.hdata_end));
  assign vact   = in_window(HCNT_W'(vcnt), HCNT_W'(sh_cfg.vdata_begin), HCNT_W'(sh_cfg.vdata_end));
  assign de     = run && hact && vact;
  assign hs_act = run && (hcnt < HCNT_W'(sh_cfg.hpulse_end));
  assign vs_act = run && (vcnt < VCNT_W'(sh_cfg.vpulse_end));

  // NOTE: shadow registers are reset too (not left as uninitialised storage)
  // so decodes are deterministic even before the first configuration load.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_cfg  <= '0;
      sh_base <= '0;
      sh_top  <= '0;
      addr    <= '0;
    end else if (load_cfg) begin
      sh_cfg  <= cfg_in;
      sh_base <= bus.base_addr_i;
      sh_top  <= bus.top_addr_i;
      addr    <= bus.base_addr_i;
    end else if (de) begin
      addr <= (addr == sh_top) ? sh_base : addr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.hsync_o       <= ~SYNC_POL;
      bus.vsync_o       <= ~SYNC_POL;
      bus.de_o          <= 1'b0;
      bus.pix_addr_o    <= '0;
      bus.line_start_o  <= 1'b0;
      bus.frame_start_o <= 1'b0;
      bus.busy_o        <= 1'b0;
    end else begin
      bus.hsync_o       <= hs_act ? SYNC_POL : ~SYNC_POL;
      bus.vsync_o       <= vs_act ? SYNC_POL : ~SYNC_POL;
      bus.de_o          <= de;
      bus.pix_addr_o    <= de ? addr : '0;
      bus.line_start_o  <= run && (hcnt == '0);
      bus.frame_start_o <= run && (hcnt == '0) && (vcnt == '0);
      bus.busy_o        <= run;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl: per-cycle timing vector checks
// against a bench-side raster model plus a fetch-address scoreboard.
module tb_vga_timing_ctrl;

  localparam int   AW = 32;
  localparam logic SP = 1'b0;

  logic clk = 1'b0;
  logic reset;

  vga_timing_ctrl_if #(.ADDR_WIDTH(AW)) vif ();

  vga_timing_ctrl #(.ADDR_WIDTH(AW), .SYNC_POL(SP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [AW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_cfg(input int hse, input int hpe, input int hdb, input int hde,
                         input int vse, input int vpe, input int vdb, input int vde,
                         input logic [AW-1:0] base, input logic [AW-1:0] top);
    vif.hsync_end_i   = 11'(hse);
    vif.hpulse_end_i  = 8'(hpe);
    vif.hdata_begin_i = 8'(hdb);
    vif.hdata_end_i   = 10'(hde);
    vif.vsync_end_i   = 9'(vse);
    vif.vpulse_end_i  = 3'(vpe);
    vif.vdata_begin_i = 5'(vdb);
    vif.vdata_end_i   = 9'(vde);
    vif.base_addr_i   = base;
    vif.top_addr_i    = top;
  endtask

  task automatic set_default_cfg(input logic [AW-1:0] top);
    set_cfg(9, 2, 3, 7, 4, 1, 2, 4, 32'h100, top);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " vec"},
          {vif.hsync_o, vif.vsync_o, vif.de_o, vif.line_start_o, vif.frame_start_o, vif.busy_o},
          {~SP, ~SP, 4'b0000});
    check({tag, " addr"}, vif.pix_addr_o, '0);
  endtask

  // Raise enable_i and check nothing is visible yet one cycle later.
  task automatic start_frame(input string tag, input bit hold);
    vif.enable_i = 1'b1;
    @(negedge clk);
    check({tag, " lat fs"}, vif.frame_start_o, 1'b0);
    check({tag, " lat busy"}, vif.busy_o, 1'b0);
    if (!hold) vif.enable_i = 1'b0;
  endtask

  // Called one negedge before the frame's first output cycle. Expected values
  // come from the configuration the bench drove when the frame was loaded.
  task automatic run_frame(input string tag, input int ncyc, input int chg_k, input int chg_hde);
    int hlen, vlen, hpe, vpe, hdb, hde, vdb, vde, h, v;
    logic [AW-1:0] base, top, a;
    logic hs, vs, dx;
    hlen = int'(vif.hsync_end_i) + 1;
    vlen = int'(vif.vsync_end_i) + 1;
    hpe  = int'(vif.hpulse_end_i);
    vpe  = int'(vif.vpulse_end_i);
    hdb  = int'(vif.hdata_begin_i);
    hde  = int'(vif.hdata_end_i);
    vdb  = int'(vif.vdata_begin_i);
    vde  = int'(vif.vdata_end_i);
    base = vif.base_addr_i;
    top  = vif.top_addr_i;
    a    = base;
    for (int vv = 0; vv < vlen; vv++) begin
      for (int hh = 0; hh < hlen; hh++) begin
        if (hh >= hdb && hh < hde && vv >= vdb && vv < vde) begin
          exp_q.push_back(a);
          a = (a == top) ? base : a + 1;
        end
      end
    end
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      h  = k % hlen;
      v  = k / hlen;
      hs = (h < hpe);
      vs = (v < vpe);
      dx = (h >= hdb) && (h < hde) && (v >= vdb) && (v < vde);
      check($sformatf("%s k=%0d vec", tag, k),
            {vif.hsync_o, vif.vsync_o, vif.de_o, vif.line_start_o, vif.frame_start_o, vif.busy_o},
            {hs ? SP : ~SP, vs ? SP : ~SP, dx, h == 0, k == 0, 1'b1});
      if (vif.de_o) begin
        if (exp_q.size() == 0) begin
          check($sformatf("%s k=%0d extra pixel", tag, k), 1, 0);
        end else begin
          check($sformatf("%s k=%0d addr", tag, k), vif.pix_addr_o, exp_q.pop_front());
        end
      end
      if (k == chg_k) vif.hdata_end_i = 10'(chg_hde);
    end
    if (ncyc == hlen * vlen) check({tag, " pixels left"}, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    vif.enable_i = 1'b0;
    set_default_cfg(32'h1FF);
    repeat (3) @(negedge clk);
    check_idle("in reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("after reset");

    // 1: single frame from a one-cycle enable pulse.
    start_frame("s1", 1'b0);
    run_frame("s1", 50, -1, 0);
    @(negedge clk);
    check_idle("s1 end");
    @(negedge clk);
    check_idle("s1 idle");

    // 2: continuous run, three back-to-back frames, enable dropped at the
    // start of the last one which must still complete.
    start_frame("s2", 1'b1);
    run_frame("s2 f1", 50, -1, 0);
    run_frame("s2 f2", 50, -1, 0);
    vif.enable_i = 1'b0;
    run_frame("s2 f3", 50, -1, 0);
    @(negedge clk);
    check_idle("s2 end");

    // 3: address wrap at top=0x104.
    set_default_cfg(32'h104);
    start_frame("s3", 1'b0);
    run_frame("s3", 50, -1, 0);
    @(negedge clk);
    check_idle("s3 end");

    // 4: hdata_end changed mid-frame only takes effect in the next frame.
    set_default_cfg(32'h1FF);
    start_frame("s4", 1'b1);
    run_frame("s4 f1", 50, 10, 9);
    vif.enable_i = 1'b0;
    run_frame("s4 f2", 50, -1, 0);
    @(negedge clk);
    check_idle("s4 end");

    // 5: reset while the counters sit at hcnt=5, vcnt=2.
    set_default_cfg(32'h1FF);
    start_frame("s5", 1'b0);
    run_frame("s5", 25, -1, 0);
    reset = 1'b1;
    @(negedge clk);
    check_idle("s5 reset");
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("s5 stay idle %0d", i),
            {vif.busy_o, vif.frame_start_o, vif.de_o}, 3'b000);
    end
    start_frame("s5 restart", 1'b0);
    run_frame("s5 restart", 50, -1, 0);
    @(negedge clk);
    check_idle("s5 restart end");

    // 6: inverted horizontal window yields no pixels.
    set_cfg(9, 2, 7, 3, 4, 1, 2, 4, 32'h100, 32'h1FF);
    start_frame("s6", 1'b0);
    run_frame("s6", 50, -1, 0);
    @(negedge clk);
    check_idle("s6 end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
